clb_config_loader: RTL

Word-serial configuration loader that sits directly upstream of the CLB LUT configuration chain (`lut_s44` and its siblings). It accepts configuration words from a valid/ready source and drives the chain's stream-style `config_en`/`config_in` for exactly one full chain length per load. As each new word shifts in, it captures the word shifted out of the chain tail and returns it on a valid/ready readback port. The block shares the chain's clock, `config_clk`.

---
 rtl/clb_config_loader_if.sv | 49 ++++
 rtl/clb_config_loader.sv | 115 +++++++++++
 2 files changed

// File: rtl/clb_config_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : clb_config_loader_if
//  Description : Bus bundle between the CLB configuration loader and its
//                neighbours: word source (in_*), LUT chain (config_*,
//                chain_tail) and readback consumer (rb_*).
//                master : source / chain / consumer side
//                slave  : the loader itself
//  Revision    : 1.0  - initial release
// ============================================================================
interface clb_config_loader_if #(
    parameter int CONFIG_WIDTH = 8
);
    logic [CONFIG_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    config_en;
    logic [CONFIG_WIDTH-1:0] config_in;
    logic [CONFIG_WIDTH-1:0] chain_tail;
    logic [CONFIG_WIDTH-1:0] rb_data;
    logic                    rb_valid;
    logic                    rb_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  config_en,
        input  config_in,
        output chain_tail,
        input  rb_data,
        input  rb_valid,
        output rb_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output config_en,
        output config_in,
        input  chain_tail,
        output rb_data,
        output rb_valid,
        input  rb_ready
    );
endinterface
`default_nettype wire

// File: rtl/clb_config_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : clb_config_loader
//  Description : Word-serial loader for the CLB LUT configuration chain.
//                Streams exactly CHAIN_WORDS words from a valid/ready source
//                into the chain and returns the words shifted out of the
//                chain tail on a valid/ready readback port.
//  Ports       : config_clk  - clock shared with the LUT chain
//                config_rst  - asynchronous active-high reset
//                start       - begin a load (sampled in IDLE only)
//                busy        - registered, high while loading
//                done        - registered one-cycle completion pulse
//                bus         - source / chain / readback signals (slave side)
//  Revision    : 1.0  - initial release
// ============================================================================
module clb_config_loader #(
    parameter int CONFIG_WIDTH = 8,
    parameter int CHAIN_WORDS  = 4
) (
    input  wire                        config_clk,
    input  wire                        config_rst,
    input  wire                        start,
    output logic                       busy,
    output logic                       done,
    clb_config_loader_if.slave         bus
);

    localparam int CNT_W = $clog2(CHAIN_WORDS + 1);
    localparam logic [CNT_W-1:0] c_last_word = CNT_W'(CHAIN_WORDS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [CONFIG_WIDTH-1:0] r_rb_data;
    logic                    r_rb_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_shift;
    logic                    w_rb_free;

    // The readback slot is free when empty or being drained this cycle;
    // a shift is only allowed then so no old chain word is ever lost.
    assign w_rb_free = !r_rb_valid || bus.rb_ready;
    assign w_shift   = (r_state == S_LOAD) && bus.in_valid && w_rb_free;

    // Accept and chain shift happen at the same edge: no pipeline stage.
    assign bus.in_ready  = w_shift;
    assign bus.config_en = w_shift;
    assign bus.config_in = bus.in_data;
    assign bus.rb_data   = r_rb_data;
    assign bus.rb_valid  = r_rb_valid;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Readback register: a shift captures the tail word as it was
            // before this edge; otherwise a consumer handshake empties it.
            if (w_shift) begin
                r_rb_data  <= bus.chain_tail;
                r_rb_valid <= 1'b1;
            end else if (bus.rb_ready) begin
                r_rb_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_shift) begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == c_last_word) begin
                            r_state <= S_FINISH;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_FINISH: begin
                    // Completion waits for the final readback word to leave.
                    if (w_rb_free) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
